// File: rtl/rd53_cmd_pkg.sv
// Shared frame constants, state/source encodings and the frame mux for the RD53 command scheduler.
package rd53_cmd_pkg;

  localparam logic [15:0] SYNC_FRAME   = 16'h817E;
  localparam logic [15:0] NOOP_FRAME   = 16'h6969;
  localparam logic [7:0]  SYNC_CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_SYNC = 2'd0,
    SRC_TRIG = 2'd1,
    SRC_CFG  = 2'd2,
    SRC_NOOP = 2'd3
  } src_e;

  // Pick the 16-bit frame for a given source.
  function automatic logic [15:0] frame_mux(input src_e sel, input logic [15:0] trig,
                                            input logic [15:0] cfg);
    case (sel)
      SRC_SYNC: frame_mux = SYNC_FRAME;
      SRC_TRIG: frame_mux = trig;
      SRC_CFG:  frame_mux = cfg;
      SRC_NOOP: frame_mux = NOOP_FRAME;
      default:  frame_mux = NOOP_FRAME;
    endcase
  endfunction

endpackage

// File: rtl/rd53_sync_timer.sv
// Counts accepted non-SYNC frames and flags when the next frame must be a SYNC.
module rd53_sync_timer
  import rd53_cmd_pkg::*;
#(
  parameter int SYNC_PERIOD = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
  input  logic cur_is_sync_i,
  output logic sync_due_o
);

  logic [7:0] sync_cnt_q;
  logic [7:0] sync_cnt_d;
  logic [8:0] cnt_after_s;

  // Saturating count of non-SYNC accepts; a SYNC accept clears it.
  always_comb begin
    sync_cnt_d = sync_cnt_q;
    if (accept_i) begin
      if (cur_is_sync_i) begin
        sync_cnt_d = 8'd0;
      end else if (sync_cnt_q != SYNC_CNT_MAX) begin
        sync_cnt_d = sync_cnt_q + 8'd1;
      end else begin
        sync_cnt_d = sync_cnt_q;
      end
    end else begin
      sync_cnt_d = sync_cnt_q;
    end
  end

  // Due is judged on the count as it stands once the frame now on the line is accepted,
  // so a SYNC lands on every SYNC_PERIOD-th frame and the count tops out at SYNC_PERIOD-1.
  always_comb begin
    if (cur_is_sync_i) begin
      cnt_after_s = 9'd0;
    end else begin
      cnt_after_s = {1'b0, sync_cnt_q} + 9'd1;
    end
    sync_due_o = (cnt_after_s >= 9'(SYNC_PERIOD - 1));
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_cnt_q <= 8'd0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
    end
  end

endmodule

// File: rtl/rd53_cmd_scheduler.sv
// Merges trigger and config frames into the RD53 command stream, with INIT lock SYNCs,
// periodic SYNC insertion, NOOP fill and atomic config bursts that SYNC never splits.
module rd53_cmd_scheduler
  import rd53_cmd_pkg::*;
#(
  parameter int SYNC_PERIOD = 32,
  parameter int INIT_SYNCS  = 32
) (
  input  logic        clk160MHz,
  input  logic        rst160MHzL,
  input  logic        trigValid,
  input  logic [15:0] trigData,
  output logic        trigReady,
  input  logic        cfgValid,
  input  logic [15:0] cfgData,
  input  logic        cfgLast,
  output logic        cfgReady,
  output logic [15:0] frameData,
  output logic        frameValid,
  input  logic        frameReady,
  output logic        initDone,
  output logic        cfgBusy
);

  localparam int ICW = (INIT_SYNCS > 1) ? $clog2(INIT_SYNCS + 1) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_SYNCS - 1);

  state_e         state_q, state_d;
  src_e           cur_src_q, cur_src_d;  // source of the frame currently on frameData
  src_e           sel_s;
  logic [15:0]    frame_q, frame_d;
  logic           valid_q;
  logic           init_done_q, init_done_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic           accept_s;
  logic           sync_due_s;

  // Nothing is accepted while reset is held, so an abandoned burst gets no further ready.
  assign accept_s = valid_q & frameReady & rst160MHzL;

  rd53_sync_timer #(.SYNC_PERIOD(SYNC_PERIOD)) u_sync_timer (
    .clk          (clk160MHz),
    .rst_n        (rst160MHzL),
    .accept_i     (accept_s),
    .cur_is_sync_i(cur_src_q == SRC_SYNC),
    .sync_due_o   (sync_due_s)
  );

  // Choose which source fills the next slot; SYNC waits for the end of a burst.
  always_comb begin
    sel_s = SRC_NOOP;
    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) sel_s = SRC_NOOP;
        else                         sel_s = SRC_SYNC;
      end
      IDLE: begin
        if (sync_due_s)     sel_s = SRC_SYNC;
        else if (trigValid) sel_s = SRC_TRIG;
        else if (cfgValid)  sel_s = SRC_CFG;
        else                sel_s = SRC_NOOP;
      end
      BURST: begin
        if (trigValid)     sel_s = SRC_TRIG;
        else if (cfgValid) sel_s = SRC_CFG;
        else               sel_s = SRC_NOOP;
      end
      default: sel_s = SRC_NOOP;
    endcase
  end

  // Next-state, next-frame and INIT bookkeeping; everything moves only on an accept.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    cur_src_d   = cur_src_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (accept_s) begin
      frame_d   = frame_mux(sel_s, trigData, cfgData);
      cur_src_d = sel_s;
      if (state_q == INIT) begin
        if (init_cnt_q == INIT_LAST) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end else if (sel_s == SRC_CFG) begin
        if (cfgLast) state_d = IDLE;
        else         state_d = BURST;
      end else begin
        state_d = state_q;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // Scheduler FSM and registered outputs; frameValid rises the first cycle out of reset.
  always_ff @(posedge clk160MHz) begin
    if (!rst160MHzL) begin
      state_q     <= INIT;
      frame_q     <= SYNC_FRAME;
      cur_src_q   <= SRC_SYNC;
      valid_q     <= 1'b0;
      init_cnt_q  <= {ICW{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      cur_src_q   <= cur_src_d;
      valid_q     <= 1'b1;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign frameData  = frame_q;
  assign frameValid = valid_q;
  assign initDone   = init_done_q;
  assign cfgBusy    = (state_q == BURST);
  assign trigReady  = accept_s & (sel_s == SRC_TRIG);
  assign cfgReady   = accept_s & (sel_s == SRC_CFG);

endmodule

// File: tb/tb_rd53_cmd_scheduler.sv
// Scoreboard bench: each issued slot queues the expected accepted frame, cfgBusy and
// ready pulses; an independent monitor pops and compares on every accept.
module tb_rd53_cmd_scheduler;

  logic        clk160MHz = 1'b0;
  logic        rst160MHzL;
  logic        trigValid;
  logic [15:0] trigData;
  logic        trigReady;
  logic        cfgValid;
  logic [15:0] cfgData;
  logic        cfgLast;
  logic        cfgReady;
  logic [15:0] frameData;
  logic        frameValid;
  logic        frameReady;
  logic        initDone;
  logic        cfgBusy;

  typedef struct packed {
    logic [15:0] data;
    logic        busy;
    logic        trdy;
    logic        crdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] trig_q[$];
  logic [16:0] cfg_q[$];

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   acc_idx      = 0;
  int   stray_ready  = 0;
  int   hold_viol    = 0;
  int   init_rdy     = 0;
  int   max_sync_cnt = 0;
  logic track_sync   = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  logic prev_acc = 1'b0;
  logic prev_rst = 1'b0;
  exp_t mon_e;

  always #5 clk160MHz = ~clk160MHz;

  rd53_cmd_scheduler #(.SYNC_PERIOD(32), .INIT_SYNCS(32)) dut (
    .clk160MHz (clk160MHz),
    .rst160MHzL(rst160MHzL),
    .trigValid (trigValid),
    .trigData  (trigData),
    .trigReady (trigReady),
    .cfgValid  (cfgValid),
    .cfgData   (cfgData),
    .cfgLast   (cfgLast),
    .cfgReady  (cfgReady),
    .frameData (frameData),
    .frameValid(frameValid),
    .frameReady(frameReady),
    .initDone  (initDone),
    .cfgBusy   (cfgBusy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on accepts plus running protocol observations.
  always @(negedge clk160MHz) begin
    if (rst160MHzL === 1'b1 && frameValid === 1'b1 && frameReady === 1'b1) begin
      acc_idx++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_accept[%0d]: frame 0x%h, no accept expected", acc_idx, frameData);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("frame_data[%0d]", acc_idx), 32'(frameData), 32'(mon_e.data));
        check($sformatf("cfg_busy[%0d]", acc_idx), 32'(cfgBusy), 32'(mon_e.busy));
        check($sformatf("trig_ready[%0d]", acc_idx), 32'(trigReady), 32'(mon_e.trdy));
        check($sformatf("cfg_ready[%0d]", acc_idx), 32'(cfgReady), 32'(mon_e.crdy));
      end
    end
    if ((trigReady === 1'b1 || cfgReady === 1'b1) &&
        !(rst160MHzL === 1'b1 && frameValid === 1'b1 && frameReady === 1'b1)) stray_ready++;
    if (trigReady === 1'b1 && cfgReady === 1'b1) stray_ready++;
    if ((trigReady === 1'b1 || cfgReady === 1'b1) && initDone !== 1'b1) init_rdy++;
    if (prev_rst && rst160MHzL === 1'b1 && !prev_acc && frameData !== prev_data) hold_viol++;
    if (track_sync && int'(dut.u_sync_timer.sync_cnt_q) > max_sync_cnt)
      max_sync_cnt = int'(dut.u_sync_timer.sync_cnt_q);
    prev_data = frameData;
    prev_rst  = (rst160MHzL === 1'b1);
    prev_acc  = (rst160MHzL === 1'b1 && frameValid === 1'b1 && frameReady === 1'b1);
  end

  task automatic present();
    if (trig_q.size() > 0) begin
      trigValid = 1'b1;
      trigData  = trig_q[0];
    end else begin
      trigValid = 1'b0;
      trigData  = 16'h0000;
    end
    if (cfg_q.size() > 0) begin
      cfgValid = 1'b1;
      cfgData  = cfg_q[0][15:0];
      cfgLast  = cfg_q[0][16];
    end else begin
      cfgValid = 1'b0;
      cfgData  = 16'h0000;
      cfgLast  = 1'b0;
    end
  endtask

  // One serializer slot: 15 cycles with frameReady low, then a one-cycle accept.
  task automatic slot(input logic [15:0] d, input logic b, input logic tr, input logic cr);
    logic t_seen;
    logic c_seen;
    logic [15:0] dummy16;
    logic [16:0] dummy17;
    exp_q.push_back({d, b, tr, cr});
    present();
    repeat (15) @(posedge clk160MHz);
    #1 frameReady = 1'b1;
    @(negedge clk160MHz);
    t_seen = trigReady;
    c_seen = cfgReady;
    @(posedge clk160MHz);
    #1 frameReady = 1'b0;
    if (t_seen && trig_q.size() > 0) dummy16 = trig_q.pop_front();
    if (c_seen && cfg_q.size() > 0) dummy17 = cfg_q.pop_front();
    present();
  endtask

  initial begin
    logic [15:0] tv;
    rst160MHzL = 1'b0;
    frameReady = 1'b0;
    trigValid  = 1'b0;
    trigData   = 16'h0000;
    cfgValid   = 1'b0;
    cfgData    = 16'h0000;
    cfgLast    = 1'b0;
    repeat (3) @(posedge clk160MHz);
    #1;
    check("reset_frame_valid", 32'(frameValid), 32'd0);
    check("reset_frame_data", 32'(frameData), 32'h0000_817E);
    check("reset_init_done", 32'(initDone), 32'd0);
    check("reset_cfg_busy", 32'(cfgBusy), 32'd0);
    rst160MHzL = 1'b1;
    @(posedge clk160MHz);
    #1;
    check("valid_after_release", 32'(frameValid), 32'd1);
    check("data_after_release", 32'(frameData), 32'h0000_817E);

    // INIT: 32 SYNCs, a pending trigger is never taken
    trig_q.push_back(16'h1111);
    for (int i = 0; i < 32; i++) slot(16'h817E, 1'b0, 1'b0, 1'b0);
    check("init_done_set", 32'(initDone), 32'd1);
    check("first_idle_frame", 32'(frameData), 32'h0000_6969);
    trig_q.delete();
    present();

    // Idle cadence: 31 NOOPs then SYNC, twice
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 31; i++) slot(16'h6969, 1'b0, 1'b0, 1'b0);
      slot(16'h817E, 1'b0, 1'b0, 1'b0);
    end

    // SYNC due and trigger pending on the same accept: SYNC first
    for (int i = 0; i < 30; i++) slot(16'h6969, 1'b0, 1'b0, 1'b0);
    trig_q.push_back(16'h2B2B);
    slot(16'h6969, 1'b0, 1'b0, 1'b0);
    slot(16'h817E, 1'b0, 1'b1, 1'b0);
    slot(16'h2B2B, 1'b0, 1'b0, 1'b0);

    // 4-frame burst, SYNC falls due after frame 2 and is deferred
    for (int i = 0; i < 27; i++) slot(16'h6969, 1'b0, 1'b0, 1'b0);
    cfg_q.push_back({1'b0, 16'h6666});
    cfg_q.push_back({1'b0, 16'h1234});
    cfg_q.push_back({1'b0, 16'h5678});
    cfg_q.push_back({1'b1, 16'h9ABC});
    slot(16'h6969, 1'b0, 1'b0, 1'b1);
    slot(16'h6666, 1'b1, 1'b0, 1'b1);
    slot(16'h1234, 1'b1, 1'b0, 1'b1);
    slot(16'h5678, 1'b1, 1'b0, 1'b1);
    slot(16'h9ABC, 1'b0, 1'b0, 1'b0);
    slot(16'h817E, 1'b0, 1'b0, 1'b0);

    // Trigger interleaved between cfg frames 2 and 3
    cfg_q.push_back({1'b0, 16'h1111});
    cfg_q.push_back({1'b0, 16'h2222});
    cfg_q.push_back({1'b0, 16'h3333});
    cfg_q.push_back({1'b1, 16'h4444});
    slot(16'h6969, 1'b0, 1'b0, 1'b1);
    slot(16'h1111, 1'b1, 1'b0, 1'b1);
    trig_q.push_back(16'hA5A5);
    slot(16'h2222, 1'b1, 1'b1, 1'b0);
    slot(16'hA5A5, 1'b1, 1'b0, 1'b1);
    slot(16'h3333, 1'b1, 1'b0, 1'b1);
    slot(16'h4444, 1'b0, 1'b0, 1'b0);

    // 100 back-to-back triggers; SYNC still every 32nd frame
    for (int i = 0; i < 100; i++) trig_q.push_back(16'h3000 + 16'(i));
    track_sync = 1'b1;
    slot(16'h6969, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 23; i++) begin tv = 16'h3000 + 16'(i); slot(tv, 1'b0, 1'b1, 1'b0); end
    slot(16'h3017, 1'b0, 1'b0, 1'b0);
    slot(16'h817E, 1'b0, 1'b1, 1'b0);
    for (int i = 24; i < 54; i++) begin tv = 16'h3000 + 16'(i); slot(tv, 1'b0, 1'b1, 1'b0); end
    slot(16'h3036, 1'b0, 1'b0, 1'b0);
    slot(16'h817E, 1'b0, 1'b1, 1'b0);
    for (int i = 55; i < 85; i++) begin tv = 16'h3000 + 16'(i); slot(tv, 1'b0, 1'b1, 1'b0); end
    slot(16'h3055, 1'b0, 1'b0, 1'b0);
    slot(16'h817E, 1'b0, 1'b1, 1'b0);
    for (int i = 86; i < 99; i++) begin tv = 16'h3000 + 16'(i); slot(tv, 1'b0, 1'b1, 1'b0); end
    slot(16'h3063, 1'b0, 1'b0, 1'b0);
    track_sync = 1'b0;
    check("sync_cnt_peak", 32'(max_sync_cnt), 32'd31);

    // Reset after cfg frame 2 has been taken: burst abandoned, INIT repeats
    cfg_q.push_back({1'b0, 16'h5151});
    cfg_q.push_back({1'b0, 16'h5252});
    cfg_q.push_back({1'b0, 16'h5353});
    cfg_q.push_back({1'b1, 16'h5454});
    slot(16'h6969, 1'b0, 1'b0, 1'b1);
    slot(16'h5151, 1'b1, 1'b0, 1'b1);
    rst160MHzL = 1'b0;
    frameReady = 1'b1;
    repeat (3) @(posedge clk160MHz);
    #1;
    check("rst2_frame_valid", 32'(frameValid), 32'd0);
    check("rst2_frame_data", 32'(frameData), 32'h0000_817E);
    check("rst2_cfg_busy", 32'(cfgBusy), 32'd0);
    check("rst2_init_done", 32'(initDone), 32'd0);
    frameReady = 1'b0;
    rst160MHzL = 1'b1;
    for (int i = 0; i < 32; i++) slot(16'h817E, 1'b0, 1'b0, 1'b0);
    check("init_done_again", 32'(initDone), 32'd1);
    slot(16'h6969, 1'b0, 1'b0, 1'b1);
    slot(16'h5353, 1'b1, 1'b0, 1'b1);
    slot(16'h5454, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk160MHz);

    check("stray_ready", 32'(stray_ready), 32'd0);
    check("ready_before_init_done", 32'(init_rdy), 32'd0);
    check("hold_without_accept", 32'(hold_viol), 32'd0);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rd53_cmd_scheduler.md
RD53_CMD_SCHEDULER -- requirements
Module: rd53_cmd_scheduler

Interface
REQ-001 SHALL have parameter SYNC_PERIOD, default 32: max frames between SYNC frames.
REQ-002 SHALL have parameter INIT_SYNCS, default 32: SYNC frames emitted after reset for chip lock.
REQ-003 SHALL have port clk160MHz  in  1  command clock; the only clock.
REQ-004 SHALL have port rst160MHzL  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port trigValid  in  1  trigger frame pending.
REQ-006 SHALL have port trigData  in  16  pre-encoded trigger frame.
REQ-007 SHALL have port trigReady  out  1  trigger frame consumed this cycle.
REQ-008 SHALL have port cfgValid  in  1  config/command frame pending.
REQ-009 SHALL have port cfgData  in  16  config frame (WrReg/RdReg/ECR/BCR/Cal).
REQ-010 SHALL have port cfgLast  in  1  last frame of an atomic config command.
REQ-011 SHALL have port cfgReady  out  1  config frame consumed this cycle.
REQ-012 SHALL have port frameData  out  16  frame offered to the CMD serializer.
REQ-013 SHALL have port frameValid  out  1  frameData valid.
REQ-014 SHALL have port frameReady  in  1  serializer accepts frame (nominally 1 pulse per 16 clk).
REQ-015 SHALL have port initDone  out  1  INIT sync sequence complete.
REQ-016 SHALL have port cfgBusy  out  1  atomic config burst in progress.

Function
REQ-017 Accept event = frameValid and frameReady in the same cycle; frameData/frameValid SHALL change only on accept or reset.
REQ-018 frameValid SHALL be 1 from the first cycle after reset release; idle slots SHALL carry NOOP 0x6969.
REQ-019 States SHALL be INIT, IDLE, BURST.
REQ-020 INIT: on each accept, next frame SHALL be SYNC 0x817E; after INIT_SYNCS SYNCs are accepted, go to IDLE and set initDone; trig/cfg never consumed in INIT.
REQ-021 syncCnt (8 bit, saturating at 255) SHALL count accepted non-SYNC frames and clear when a SYNC frame is accepted; syncDue = syncCnt >= SYNC_PERIOD-1.
REQ-022 IDLE next-frame priority SHALL be: SYNC if syncDue > trigData if trigValid > cfgData if cfgValid > NOOP.
REQ-023 BURST next-frame priority SHALL be: trigData if trigValid > cfgData if cfgValid > NOOP; SYNC SHALL be deferred, even when due, until the burst ends.
REQ-024 Consuming a cfg frame with cfgLast=0 in IDLE SHALL enter BURST; consuming a cfg frame with cfgLast=1 SHALL return to IDLE; cfgLast=1 in IDLE stays IDLE.
REQ-025 trigReady/cfgReady SHALL be single-cycle combinational pulses, asserted only in the accept cycle and only for the selected source; never both.
REQ-026 Latency: a source valid before an accept SHALL be loaded into frameData on that accept (zero idle slot) when it wins priority.
REQ-027 Triggers SHALL be interleavable inside a config burst; config frames SHALL never be split by SYNC.
REQ-028 cfgBusy SHALL equal state==BURST.
REQ-029 With frameReady held low, outputs SHALL hold and no ready SHALL assert.

Reset
REQ-030 On rst160MHzL=0 at a clock edge: state=INIT, frameValid=0, frameData=0x817E, syncCnt=0, INIT counter=0, initDone=0, cfgBusy=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no further cfgReady; after release, INIT SHALL repeat in full.

Structure
REQ-032 Package rd53_cmd_pkg SHALL hold SYNC_FRAME, NOOP_FRAME, the state enum (INIT/IDLE/BURST) and the source-select enum (SYNC/TRIG/CFG/NOOP).
REQ-033 Sync counting and syncDue SHALL live in sub-module rd53_sync_timer; arbitration and the FSM stay in the top.

Verification
REQ-034 Reset, then frameReady every 16th cycle, INIT_SYNCS=32 -> 32 frames 0x817E, then initDone=1, then 0x6969 idle, with SYNC every 32nd frame.
REQ-035 IDLE with syncDue and trigValid (trigData=0x2B2B) on the same accept -> SYNC first, trigger on the next accept, trigReady pulses once.
REQ-036 4-frame burst (0x6666, 0x1234, 0x5678, 0x9ABC with cfgLast on the 4th), with SYNC due after frame 2 -> 4 frames contiguous, SYNC immediately after, cfgBusy high for frames 1-3.
REQ-037 Trigger asserted mid-burst -> trigData between cfg frames 2 and 3; burst otherwise intact; cfgReady is not asserted in that slot.
REQ-038 Continuous trigValid for 100 frames -> SYNC still emitted every 32 frames and syncCnt never exceeds 31.
REQ-039 Reset pulsed after cfg frame 2 of a burst -> no cfgReady until initDone, then 32 SYNC frames re-emitted.
